ps2_ascii_decoder: RTL
======================

# ps2_ascii_decoder

Converts the PS/2 Set-2 scan-code byte stream from the keyboard receiver into ASCII characters for the LCD write path. It sits directly downstream of `keyboard`, one byte per `code_valid_i` pulse. It tracks make/break (`F0`) and extended (`E0`) prefixes, Shift and Caps Lock state, and optional auto-repeat suppression. It emits one ASCII byte with a one-cycle valid strobe per printable key press.

## Interface
- `FILTER_REPEAT`, default 0: when set to 1, repeated make codes of the same key are suppressed until that key's break code arrives.
- `clk`  in  1  system clock (50 MHz); the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `code_i`  in  8  scan-code byte from the keyboard receiver.
- `code_valid_i`  in  1  one-cycle pulse; `code_i` is valid in that cycle.
- `ascii_o`  out  8  last decoded character; holds its value between strobes.
- `ascii_valid_o`  out  1  one-cycle pulse when `ascii_o` is updated.
- `shift_o`  out  1  1 while either Shift key is held.
- `caps_o`  out  1  Caps Lock toggle state.

## Operation
- Reset values: `ascii_o`=0x00, `ascii_valid_o`=0, `shift_o`=0, `caps_o`=0, FSM=IDLE, last-key register=0x00.
- FSM has four states: IDLE, BRK (after `F0`), EXT (after `E0`), EXT_BRK (after `E0 F0`).
- IDLE transitions:
  - `F0` → BRK.
  - `E0` → EXT.
  - Any other byte is a make event → stay in IDLE.
- EXT transitions:
  - `F0` → EXT_BRK.
  - Any other byte is an extended make → IDLE.
- BRK and EXT_BRK: the next byte is a break event → IDLE.
- Bytes with `code_valid_i`=0 are ignored. The FSM advances only on strobes.
- Make events in IDLE:
  - `12` or `59`: set the corresponding shift flag. No output.
  - `58`: toggle `caps_o`, only if Caps is not already held. A held-Caps flag prevents repeat toggling; break `58` clears it. No output.
  - Mapped printable key: emit ASCII.
  - Unmapped key, including `AA`, `FA`, `EE`, `FE`, `00`, `FF`: no output.
- Break events: `12`/`59` clear the corresponding shift flag. All other break events produce no output. Break events clear the last-key register when the code matches.
- Extended make: only `E0 5A` (keypad Enter) emits 0x0D. All other extended codes produce no output. Extended break events produce no output.
- Character mapping:
  - Letters: uppercase when `shift_o` XOR `caps_o`. `1C` → 'a' 0x61 / 'A' 0x41.
  - Digits and symbols: use Shift only, ignoring Caps. `16` → '1' 0x31 / '!' 0x21. `4E` → '-' / '_'.
  - Fixed codes: `29` → 0x20, `5A` → 0x0D, `66` → 0x08, `0D` → 0x09.
- FILTER_REPEAT=1: if a mapped make code equals the last-key register, no output. Otherwise emit and store the code. FILTER_REPEAT=0: every make code emits.
- `shift_o` = left-shift flag OR right-shift flag.

## Timing
- Latency: `ascii_valid_o` pulses exactly 1 cycle after the `code_valid_i` cycle of the final byte. `ascii_o` is valid in that same cycle.
- Modifier outputs update 1 cycle after the strobe of the byte that changes them.
- Back-to-back strobes on consecutive cycles are accepted. Each strobe is processed independently with no stalls; there is no ready/backpressure signal.
- `rst` asserted mid-sequence (e.g. after `F0`) discards the prefix. The following byte is treated as a make from IDLE.
- `rst` concurrent with `code_valid_i`: reset wins and the byte is dropped.
- `ascii_valid_o` never stays high for 2 consecutive cycles unless 2 make strobes arrive on consecutive cycles.

## Structure
- Package `ps2_kbd_pkg` holds:
  - Constants `SC_BREAK`=8'hF0, `SC_EXT`=8'hE0, `SC_LSHIFT`=8'h12, `SC_RSHIFT`=8'h59, `SC_CAPS`=8'h58, `SC_ENTER`=8'h5A.
  - The FSM state typedef.
  - ASCII constants for CR, BS, TAB, and SP.
- Sub-module `ps2_scancode_rom` is purely combinational:
  - Inputs: code[7:0], shift, caps.
  - Outputs: ascii[7:0], hit (1 when the code is mapped).
- The top level holds the FSM, modifier flags, last-key register, and output registers.

## Test plan
- Reset, then strobe `1C`, `F0`, `1C` → one `ascii_valid_o` pulse with `ascii_o`=0x61, 1 cycle after the first strobe. No pulse for the break.
- `12`, `1C`, `16`, `F0 12`, `1C` → outputs 0x41, 0x21, 0x61. `shift_o` goes 1 after `12` and returns to 0 after `F0 12`.
- `58`, `58`, `F0 58`, `1C`, `16` → `caps_o`=1 (the held repeat does not toggle it), outputs 0x41 then 0x31. A second `58`, `F0 58` → `caps_o`=0.
- `E0 5A` → 0x0D. `E0 75`, `E0 F0 75` → no output and no modifier change. `F0` then `rst` then `1C` → 0x61.
- FILTER_REPEAT=1: `1C 1C 1C F0 1C 1C` → exactly two pulses, both 0x61. With FILTER_REPEAT=0 the same sequence gives four pulses.
- `AA`, `FA`, `00` → no output. Back-to-back strobes `29`, `66` on consecutive cycles → pulses 0x20, 0x08 on consecutive cycles.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_pkg
// Description : Shared PS/2 Set-2 scan-code constants, ASCII control codes
//               and the decoder FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_kbd_pkg;

  // Scan-code prefixes and modifier keys (Set 2)
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // ASCII control characters
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_SP  = 8'h20;

  // Prefix-tracking FSM
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;  // expecting a make code or prefix
  localparam state_t ST_BRK     = 2'd1;  // after F0
  localparam state_t ST_EXT     = 2'd2;  // after E0
  localparam state_t ST_EXT_BRK = 2'd3;  // after E0 F0

endpackage
`default_nettype wire

// File: rtl/ps2_scancode_rom.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_rom
// Description : Combinational Set-2 make-code to ASCII lookup. Letters obey
//               Shift XOR Caps; digits and symbols obey Shift only.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_rom
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       shift_i,
    input  logic       caps_i,
    output logic [7:0] ascii_o,
    output logic       hit_o
);

    logic       w_is_letter;
    logic [7:0] w_lo_ch;
    logic [7:0] w_hi_ch;

    // Table lookup: {hit, letter, unshifted, shifted}
    always_comb begin
        {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = 18'd0;
        case (code_i)
            8'h1C: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "a", "A"};
            8'h32: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "b", "B"};
            8'h21: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "c", "C"};
            8'h23: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "d", "D"};
            8'h24: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "e", "E"};
            8'h2B: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "f", "F"};
            8'h34: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "g", "G"};
            8'h33: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "h", "H"};
            8'h43: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "i", "I"};
            8'h3B: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "j", "J"};
            8'h42: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "k", "K"};
            8'h4B: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "l", "L"};
            8'h3A: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "m", "M"};
            8'h31: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "n", "N"};
            8'h44: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "o", "O"};
            8'h4D: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "p", "P"};
            8'h15: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "q", "Q"};
            8'h2D: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "r", "R"};
            8'h1B: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "s", "S"};
            8'h2C: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "t", "T"};
            8'h3C: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "u", "U"};
            8'h2A: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "v", "V"};
            8'h1D: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "w", "W"};
            8'h22: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "x", "X"};
            8'h35: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "y", "Y"};
            8'h1A: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b11, "z", "Z"};
            8'h16: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "1", "!"};
            8'h1E: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "2", "@"};
            8'h26: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "3", "#"};
            8'h25: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "4", 8'h24};
            8'h2E: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "5", "%"};
            8'h36: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "6", "^"};
            8'h3D: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "7", "&"};
            8'h3E: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "8", "*"};
            8'h46: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "9", "("};
            8'h45: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "0", ")"};
            8'h0E: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, 8'h60, "~"};
            8'h4E: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "-", "_"};
            8'h55: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "=", "+"};
            8'h54: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "[", "{"};
            8'h5B: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "]", "}"};
            8'h5D: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, 8'h5C, "|"};
            8'h4C: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, ";", ":"};
            8'h52: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, 8'h27, 8'h22};
            8'h41: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, ",", "<"};
            8'h49: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, ".", ">"};
            8'h4A: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, "/", "?"};
            8'h29: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, ASCII_SP,  ASCII_SP};
            8'h5A: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, ASCII_CR,  ASCII_CR};
            8'h66: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, ASCII_BS,  ASCII_BS};
            8'h0D: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = {2'b10, ASCII_TAB, ASCII_TAB};
            default: {hit_o, w_is_letter, w_lo_ch, w_hi_ch} = 18'd0;
        endcase
    end

    // Case selection: Caps only affects letters
    always_comb begin
        if (w_is_letter) begin
            ascii_o = (shift_i ^ caps_i) ? w_hi_ch : w_lo_ch;
        end else begin
            ascii_o = shift_i ? w_hi_ch : w_lo_ch;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_ascii_decoder
// Description : PS/2 Set-2 scan-code stream to ASCII. Tracks F0/E0 prefixes,
//               Shift and Caps Lock, optional auto-repeat suppression, and
//               emits one ASCII byte with a one-cycle strobe per key press.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FILTER_REPEAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_i,
  input  logic       code_valid_i,
  output logic [7:0] ascii_o,
  output logic       ascii_valid_o,
  output logic       shift_o,
  output logic       caps_o
);

  state_t     state_q, state_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;
  logic       caps_held_q, caps_held_d;
  logic [7:0] last_q, last_d;
  logic [7:0] ascii_q, ascii_d;
  logic       valid_q, valid_d;

  logic [7:0] rom_ascii;
  logic       rom_hit;

  ps2_scancode_rom u_rom (
    .code_i  (code_i),
    .shift_i (shift_o),
    .caps_i  (caps_q),
    .ascii_o (rom_ascii),
    .hit_o   (rom_hit)
  );

  // Next-state: prefix FSM, modifier tracking and character emission
  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    last_d      = last_q;
    ascii_d     = ascii_q;
    valid_d     = 1'b0;
    if (code_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (code_i == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (code_i == SC_EXT) begin
            state_d = ST_EXT;
          end else if (code_i == SC_LSHIFT) begin
            lshift_d = 1'b1;
          end else if (code_i == SC_RSHIFT) begin
            rshift_d = 1'b1;
          end else if (code_i == SC_CAPS) begin
            // Typematic repeats of a held Caps key must not re-toggle
            if (!caps_held_q) begin
              caps_d = ~caps_q;
            end
            caps_held_d = 1'b1;
          end else if (rom_hit) begin
            if (!((FILTER_REPEAT != 0) && (code_i == last_q))) begin
              ascii_d = rom_ascii;
              valid_d = 1'b1;
              last_d  = code_i;
            end
          end
        end
        ST_EXT: begin
          if (code_i == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
            // Keypad Enter is the only extended key that prints
            if (code_i == SC_ENTER) begin
              ascii_d = ASCII_CR;
              valid_d = 1'b1;
            end
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (code_i == SC_LSHIFT) lshift_d = 1'b0;
          if (code_i == SC_RSHIFT) rshift_d = 1'b0;
          if (code_i == SC_CAPS)   caps_held_d = 1'b0;
          if (code_i == last_q)    last_d = 8'h00;
        end
        default: begin  // ST_EXT_BRK
          state_d = ST_IDLE;
          if (code_i == last_q) last_d = 8'h00;
        end
      endcase
    end
  end

  // State registers; reset overrides any concurrent strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      last_q      <= 8'h00;
      ascii_q     <= 8'h00;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      last_q      <= last_d;
      ascii_q     <= ascii_d;
      valid_q     <= valid_d;
    end
  end

  assign ascii_o       = ascii_q;
  assign ascii_valid_o = valid_q;
  assign shift_o       = lshift_q | rshift_q;
  assign caps_o        = caps_q;

endmodule
`default_nettype wire
